// File: rtl/iteration_vector_sequencer_pkg.sv
// Shared FSM encoding and config address map for the loop-nest sequencer.
// Address helpers take the dimension count because the package is not parameterized.
package iteration_vector_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LB_BASE = 0;

    function automatic int ub_base(input int dim);
        return dim;
    endfunction

    function automatic int sel_addr(input int dim);
        return 2 * dim;
    endfunction

endpackage

// File: rtl/iteration_vector_sequencer_stage.sv
// One loop dimension: programmable signed bounds plus its counter.
// The counter reloads to lb when it is stepped at ub and passes the carry up the nest.
module ivar_counter_stage
    import iteration_vector_sequencer_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lb_we,
    input  logic                ub_we,
    input  logic [W-1:0]        wdata,
    input  logic                load,
    input  logic                step_in,
    output logic signed [W-1:0] value,
    output logic                at_ub,
    output logic                lb_le_ub,
    output logic                carry_out
);

    logic signed [W-1:0] lb_q;
    logic signed [W-1:0] ub_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lb_q  <= '0;
            ub_q  <= '0;
            value <= '0;
        end else begin
            if (lb_we) lb_q <= wdata;
            if (ub_we) ub_q <= wdata;
            // The increment is never taken at ub, so ub = max signed cannot wrap.
            if (load)
                value <= lb_q;
            else if (step_in)
                value <= at_ub ? lb_q : value + W'(1);
        end
    end

    assign at_ub     = (value == ub_q);
    assign lb_le_ub  = (lb_q <= ub_q);
    assign carry_out = step_in & at_ub;

endmodule

// File: rtl/iteration_vector_sequencer.sv
// Loop-nest sequencer: walks a DIMENSION-deep rectangular space one point per advance,
// dimension 0 innermost, and drives the packed iteration vector plus mux select word.
module iteration_vector_sequencer
    import iteration_vector_sequencer_pkg::*;
#(
    parameter int ITERATION_VARIABLE_WIDTH = 16,
    parameter int DIMENSION                = 3,
    parameter int CFG_ADDR_WIDTH           = 4
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             cfg_we,
    input  logic [CFG_ADDR_WIDTH-1:0]                        cfg_addr,
    input  logic [ITERATION_VARIABLE_WIDTH-1:0]              cfg_data,
    input  logic                                             start,
    input  logic                                             advance,
    output logic [0:DIMENSION*ITERATION_VARIABLE_WIDTH-1]    ivar,
    output logic [DIMENSION-1:0]                             ivar_sel,
    output logic                                             ivar_valid,
    output logic                                             last,
    output logic                                             busy,
    output logic                                             done
);

    localparam int W = ITERATION_VARIABLE_WIDTH;
    localparam int D = DIMENSION;
    localparam logic [CFG_ADDR_WIDTH-1:0] SEL_A = CFG_ADDR_WIDTH'(sel_addr(D));

    state_t state_q, state_d;

    logic [D-1:0]        at_ub, lb_le_ub, carry, step_in, lb_we, ub_we;
    logic [D-1:0][W-1:0] value;
    logic                cfg_wr, start_ok, step, last_raw;

    // A write coinciding with start is dropped so start sees the old bounds.
    assign cfg_wr   = cfg_we & (state_q == IDLE) & ~start;
    assign start_ok = (state_q == IDLE) & start & (&lb_le_ub);
    assign last_raw = &at_ub;
    assign step     = (state_q == RUN) & advance & ~last_raw;

    genvar k;
    generate
        for (k = 0; k < D; k++) begin : g_dim
            localparam logic [CFG_ADDR_WIDTH-1:0] LB_A = CFG_ADDR_WIDTH'(LB_BASE + k);
            localparam logic [CFG_ADDR_WIDTH-1:0] UB_A = CFG_ADDR_WIDTH'(ub_base(D) + k);

            assign lb_we[k] = cfg_wr & (cfg_addr == LB_A);
            assign ub_we[k] = cfg_wr & (cfg_addr == UB_A);

            if (k == 0) begin : g_inner
                assign step_in[k] = step;
            end else begin : g_outer
                assign step_in[k] = carry[k-1];
            end

            ivar_counter_stage #(.W(W)) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .lb_we     (lb_we[k]),
                .ub_we     (ub_we[k]),
                .wdata     (cfg_data),
                .load      (start_ok),
                .step_in   (step_in[k]),
                .value     (value[k]),
                .at_ub     (at_ub[k]),
                .lb_le_ub  (lb_le_ub[k]),
                .carry_out (carry[k])
            );

            assign ivar[k*W +: W] = value[k];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ivar_sel <= '0;
        end else begin
            state_q <= state_d;
            if (cfg_wr && cfg_addr == SEL_A)
                ivar_sel <= cfg_data[D-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        ivar_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = (&lb_le_ub) ? RUN : DONE;
            RUN: begin
                ivar_valid = 1'b1;
                busy       = 1'b1;
                if (advance && last_raw) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        last = last_raw & ivar_valid;
    end

endmodule

// File: tb/tb_iteration_vector_sequencer.sv
// Scoreboard bench for the loop-nest sequencer: a nested-loop model queues the expected
// points at start, and a negedge monitor checks each presented point against the queue head.
module tb_iteration_vector_sequencer;

    localparam int W = 16;
    localparam int D = 3;
    localparam int A = 4;

    logic             clk = 1'b0;
    logic             rst_n, cfg_we, start, advance;
    logic [A-1:0]     cfg_addr;
    logic [W-1:0]     cfg_data;
    logic [0:D*W-1]   ivar;
    logic [D-1:0]     ivar_sel;
    logic             ivar_valid, last, busy, done;

    iteration_vector_sequencer #(
        .ITERATION_VARIABLE_WIDTH(W), .DIMENSION(D), .CFG_ADDR_WIDTH(A)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .advance(advance), .ivar(ivar), .ivar_sel(ivar_sel),
        .ivar_valid(ivar_valid), .last(last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [0:D*W-1] vec;
        logic           last;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0, n_fail = 0;
    bit   mon_en = 1'b0;
    int   done_cyc = -1, done_cnt = 0, valid_cnt = 0;
    int   m_lb[D], m_ub[D];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", 64'(busy), 64'(ivar_valid));
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                chk("done_valid", 64'(ivar_valid), '0);
            end
            if (!ivar_valid) begin
                chk("last_gate", 64'(last), '0);
            end else begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    chk("extra_point", 64'(ivar_valid), '0);
                end else begin
                    chk("ivar", 64'(ivar), 64'(exp_q[0].vec));
                    chk("last", 64'(last), 64'(exp_q[0].last));
                    if (advance) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cfg(input int a, input int d);
        cfg_we = 1'b1; cfg_addr = A'(a); cfg_data = W'(d);
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic set_bounds(input int l0, input int l1, input int l2,
                              input int u0, input int u1, input int u2);
        m_lb = '{l0, l1, l2};
        m_ub = '{u0, u1, u2};
        for (int k = 0; k < D; k++) begin
            cfg(k, m_lb[k]);
            cfg(D + k, m_ub[k]);
        end
    endtask

    task automatic push_model(output int p);
        exp_t e;
        p = 0;
        for (int i2 = m_lb[2]; i2 <= m_ub[2]; i2++)
            for (int i1 = m_lb[1]; i1 <= m_ub[1]; i1++)
                for (int i0 = m_lb[0]; i0 <= m_ub[0]; i0++) begin
                    e.vec[0*W +: W] = W'(i0);
                    e.vec[1*W +: W] = W'(i1);
                    e.vec[2*W +: W] = W'(i2);
                    e.last = (i0 == m_ub[0]) && (i1 == m_ub[1]) && (i2 == m_ub[2]);
                    exp_q.push_back(e);
                    p++;
                end
    endtask

    // Start a nest and drive advance until done; stalls cover cycles stall_at and stall_at+1.
    task automatic run_nest(input int stall_at, input int exp_rel,
                            input bit wr_at_start, input bit wr_in_run);
        int s, d0;
        done_cyc = -1;
        d0 = done_cnt;
        start = 1'b1;
        s = cyc;
        if (wr_at_start) begin cfg_we = 1'b1; cfg_addr = '0; cfg_data = '0; end
        tick;
        start = 1'b0; cfg_we = 1'b0;
        for (int r = 1; r <= 200; r++) begin
            advance = !(stall_at > 0 && (r == stall_at || r == stall_at + 1));
            cfg_we = 1'b0;
            if (wr_in_run && r == 1) begin cfg_we = 1'b1; cfg_addr = '0; cfg_data = 16'd7; end
            if (wr_in_run && r == 2) begin cfg_we = 1'b1; cfg_addr = A'(2*D); cfg_data = 16'd2; end
            @(negedge clk); #1;
            if (done_cyc >= 0) break;
            @(posedge clk); #1;
        end
        advance = 1'b0; cfg_we = 1'b0;
        chk("done_cycle", 64'(done_cyc - s), 64'(exp_rel));
        chk("scoreboard_empty", 64'(exp_q.size()), '0);
        exp_q.delete();
        tick;
        @(negedge clk); #1;
        chk("done_pulses", 64'(done_cnt - d0), 64'(1));
        tick;
    endtask

    initial begin
        int p, v0;
        rst_n = 1'b0; cfg_we = 1'b0; start = 1'b0; advance = 1'b0;
        cfg_addr = '0; cfg_data = '0;
        tick; tick;
        @(negedge clk);
        chk("rst_ivar", 64'(ivar), '0);
        chk("rst_sel", 64'(ivar_sel), '0);
        chk("rst_valid", 64'(ivar_valid), '0);
        chk("rst_last", 64'(last), '0);
        chk("rst_busy", 64'(busy), '0);
        chk("rst_done", 64'(done), '0);
        tick;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Basic 2x3x2 nest.
        set_bounds(0, 0, 0, 1, 2, 1);
        push_model(p);
        run_nest(0, p + 1, 1'b0, 1'b0);

        // Two stalled cycles must hold the vector.
        push_model(p);
        run_nest(2, p + 3, 1'b0, 1'b0);

        // Writes during RUN are dropped; inner reloads must still use lb0=0.
        push_model(p);
        run_nest(0, p + 1, 1'b0, 1'b1);
        chk("sel_frozen", 64'(ivar_sel), '0);

        // Same writes in IDLE take effect; unmapped address ignored.
        cfg(15, 16'h1234);
        set_bounds(7, 0, 0, 7, 2, 1);
        cfg(2*D, 2);
        chk("sel_written", 64'(ivar_sel), 64'(3'b010));
        push_model(p);
        run_nest(0, p + 1, 1'b0, 1'b0);

        // Signed bounds; a write colliding with start is ignored, then re-run to confirm.
        set_bounds(-2, 5, 5, 1, 5, 5);
        push_model(p);
        run_nest(0, p + 1, 1'b1, 1'b0);
        push_model(p);
        run_nest(0, p + 1, 1'b0, 1'b0);

        // ub at max signed value.
        set_bounds(32766, 32767, 32767, 32767, 32767, 32767);
        push_model(p);
        run_nest(0, p + 1, 1'b0, 1'b0);

        // Empty space: done the cycle after start, never valid.
        set_bounds(0, 3, 0, 1, 2, 1);
        v0 = valid_cnt;
        push_model(p);
        run_nest(0, 1, 1'b0, 1'b0);
        chk("empty_valid", 64'(valid_cnt - v0), '0);

        // Reset mid-run at the fifth point.
        set_bounds(0, 0, 0, 1, 2, 1);
        push_model(p);
        v0 = done_cnt;
        start = 1'b1;
        tick;
        start = 1'b0; advance = 1'b1;
        repeat (4) tick;
        advance = 1'b0; rst_n = 1'b0; mon_en = 1'b0;
        tick;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ivar", 64'(ivar), '0);
        chk("mid_rst_valid", 64'(ivar_valid), '0);
        chk("mid_rst_busy", 64'(busy), '0);
        chk("mid_rst_last", 64'(last), '0);
        chk("mid_rst_sel", 64'(ivar_sel), '0);
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst_no_done", 64'(done), '0);
            @(negedge clk);
        end
        chk("mid_rst_done_cnt", 64'(done_cnt - v0), '0);
        exp_q.delete();
        tick;
        mon_en = 1'b1;
        m_lb = '{0, 0, 0};
        m_ub = '{0, 0, 0};
        push_model(p);
        run_nest(0, p + 1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
